fetch_pc_unit: RTL and testbench

//  Program-counter and instruction-fetch stage of the RV32 core. It consumes the
//  {address_target, flag_branch} pair that the execute stage produces and redirects

---
 rtl/fetch_pc_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - RV32 program counter and single-outstanding instruction fetch stage
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resolve_valid,
    input  logic [1:0]  flag_branch,
    input  logic [31:0] address_target,
    input  logic        branch_taken,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        flush,
    output logic        misaligned
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_HALT
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_kill;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_flush;
    logic        r_misaligned;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_kill_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_instr_pc_nxt;
    logic        w_flush_nxt;
    logic        w_misaligned_nxt;

    logic        w_redir;
    logic        w_redir_act;
    logic [31:0] w_tgt;

    assign w_redir = resolve_valid & ((flag_branch == 2'b01) | (flag_branch == 2'b10) |
                                      ((flag_branch == 2'b11) & branch_taken));
    // JALR clears bit0 of the computed target
    assign w_tgt = {address_target[31:1], address_target[0] & (flag_branch != 2'b10)};
    assign w_redir_act = w_redir & (r_state != S_BOOT) & (r_state != S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_instr      <= 32'h0;
            r_instr_pc   <= 32'h0;
            r_flush      <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_kill       <= w_kill_nxt;
            r_instr      <= w_instr_nxt;
            r_instr_pc   <= w_instr_pc_nxt;
            r_flush      <= w_flush_nxt;
            r_misaligned <= w_misaligned_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_kill_nxt       = r_kill;
        w_instr_nxt      = r_instr;
        w_instr_pc_nxt   = r_instr_pc;
        w_flush_nxt      = 1'b0;
        w_misaligned_nxt = r_misaligned;

        case (r_state)
            S_BOOT: w_state_nxt = S_REQ;
            S_REQ: begin
                if (imem_gnt) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (r_kill) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_instr_nxt    = imem_rdata;
                        w_instr_pc_nxt = r_pc;
                        w_pc_nxt       = r_pc + 32'd4;
                        w_state_nxt    = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (!stall) w_state_nxt = S_REQ;
            end
            S_HALT: w_state_nxt = S_HALT;
            default: w_state_nxt = S_BOOT;
        endcase

        // Redirect overrides the sequential decisions above, including stall
        if (w_redir_act) begin
            w_instr_nxt    = r_instr;
            w_instr_pc_nxt = r_instr_pc;
            if (w_tgt[1]) begin
                w_misaligned_nxt = 1'b1;
                w_kill_nxt       = 1'b0;
                w_pc_nxt         = r_pc;
                w_state_nxt      = S_HALT;
            end else begin
                w_pc_nxt    = {w_tgt[31:2], 2'b00};
                w_flush_nxt = 1'b1;
                case (r_state)
                    S_REQ: begin
                        if (imem_gnt) begin
                            w_kill_nxt  = 1'b1;
                            w_state_nxt = S_WAIT;
                        end else begin
                            w_state_nxt = S_REQ;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            w_kill_nxt  = 1'b0;
                            w_state_nxt = S_REQ;
                        end else begin
                            w_kill_nxt  = 1'b1;
                            w_state_nxt = S_WAIT;
                        end
                    end
                    default: w_state_nxt = S_REQ;
                endcase
            end
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == S_OUT);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign flush       = r_flush;
    assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        resolve_valid;
    logic [1:0]  flag_branch;
    logic [31:0] address_target;
    logic        branch_taken;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        flush;
    logic        misaligned;

    int n_pass  = 0;
    int n_total = 0;

    fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .resolve_valid  (resolve_valid),
        .flag_branch    (flag_branch),
        .address_target (address_target),
        .branch_taken   (branch_taken),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .flush          (flush),
        .misaligned     (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic redirect(input logic [1:0] f, input logic [31:0] t, input logic tk);
        resolve_valid  = 1'b1;
        flag_branch    = f;
        address_target = t;
        branch_taken   = tk;
    endtask

    task automatic no_redirect();
        resolve_valid  = 1'b0;
        flag_branch    = 2'b00;
        address_target = 32'h0;
        branch_taken   = 1'b0;
    endtask

    // Starts at a negedge in REQ; 1-cycle gnt, rvalid two cycles after gnt; ends at a negedge in OUT
    task automatic fetch(input logic [31:0] word);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        no_redirect();
        step();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_mis", {31'h0, misaligned}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("boot_req", {31'h0, imem_req}, 32'h1);
        chk("boot_addr", imem_addr, 32'h0);

        fetch(32'h0050_0093);
        chk("t1_valid", {31'h0, instr_valid}, 32'h1);
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_pc", instr_pc, 32'h0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_instr", instr, 32'h0050_0093);
            chk("t2_pc", instr_pc, 32'h0);
            chk("t2_req", {31'h0, imem_req}, 32'h0);
            chk("t2_valid", {31'h0, instr_valid}, 32'h1);
        end
        stall = 1'b0;
        step();
        chk("t1_next_addr", imem_addr, 32'h4);
        chk("t1_next_req", {31'h0, imem_req}, 32'h1);

        fetch(32'h1111_1111);
        chk("a4_pc", instr_pc, 32'h4);
        step();
        chk("a8_addr", imem_addr, 32'h8);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        redirect(2'b01, 32'h100, 1'b0);
        step();
        no_redirect();
        chk("t3_flush", {31'h0, flush}, 32'h1);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("t3_flush_once", {31'h0, flush}, 32'h0);
        chk("t3_no_stale", instr, 32'h1111_1111);
        chk("t3_valid", {31'h0, instr_valid}, 32'h0);
        chk("t3_addr", imem_addr, 32'h100);
        chk("t3_req", {31'h0, imem_req}, 32'h1);

        redirect(2'b10, 32'h205, 1'b0);
        step();
        no_redirect();
        chk("t4_jalr_flush", {31'h0, flush}, 32'h1);
        chk("t4_jalr_addr", imem_addr, 32'h204);
        fetch(32'h2222_2222);
        chk("t4_instr_pc", instr_pc, 32'h204);
        redirect(2'b11, 32'h400, 1'b0);
        step();
        no_redirect();
        chk("t4_nt_flush", {31'h0, flush}, 32'h0);
        chk("t4_nt_addr", imem_addr, 32'h208);

        imem_gnt = 1'b1;
        redirect(2'b11, 32'h300, 1'b1);
        step();
        imem_gnt = 1'b0;
        no_redirect();
        chk("kill_flush", {31'h0, flush}, 32'h1);
        chk("kill_req", {31'h0, imem_req}, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        step();
        imem_rvalid = 1'b0;
        chk("kill_instr", instr, 32'h2222_2222);
        chk("kill_addr", imem_addr, 32'h300);
        chk("kill_req2", {31'h0, imem_req}, 32'h1);

        redirect(2'b01, 32'hFFFF_FFFC, 1'b0);
        step();
        no_redirect();
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h3333_3333);
        chk("t6_instr_pc", instr_pc, 32'hFFFF_FFFC);
        step();
        chk("t6_wrap", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", {31'h0, imem_req}, 32'h0);
        chk("t6_rst_addr", imem_addr, 32'h0);
        chk("t6_rst_instr", instr, 32'h0);
        chk("t6_rst_pc", instr_pc, 32'h0);
        chk("t6_rst_valid", {31'h0, instr_valid}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_restart_req", {31'h0, imem_req}, 32'h1);
        chk("t6_restart_addr", imem_addr, 32'h0);

        redirect(2'b01, 32'h102, 1'b0);
        step();
        no_redirect();
        chk("t5_mis", {31'h0, misaligned}, 32'h1);
        chk("t5_flush", {31'h0, flush}, 32'h0);
        imem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_req", {31'h0, imem_req}, 32'h0);
            chk("t5_mis_sticky", {31'h0, misaligned}, 32'h1);
        end
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_mis", {31'h0, misaligned}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
